// File: rtl/quad_step_decoder.sv
// Quadrature front end: sync, glitch filter, Gray-code FSM.
// Optional saturating error counter enabled by QDEC_ERR_CNT_EN.
module quad_step_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic       C,
  input  logic       CLR,
  input  logic       A,
  input  logic       B,
  output logic       Step,
  output logic       Up_Down,
  output logic       Err,
  output logic [3:0] Err_Cnt
);

  localparam logic [3:0] FL = 4'(FILT_LEN);

  typedef enum logic {INIT, TRACK} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] f;
  logic [1:0] f_nxt;
  logic [1:0] cand;
  logic [1:0] cand_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] n;
  logic       hit;
  logic       up;
  logic       dn;
  logic       step_nxt;
  logic       ud_nxt;
  logic       err_nxt;

  // Two-flop synchronizer for both phases
  always_ff @(posedge C) begin
    if (CLR) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {A, B};
      s2 <= s1;
    end
  end

  // Stability count, acceptance and Gray-code decode
  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    step_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ud_nxt    = Up_Down;
    n   = (cnt != 4'd0 && s2 == cand) ? cnt + 4'd1 : 4'd1;
    hit = (n == FL);
    up  = (f == 2'b00 && s2 == 2'b10) ||
          (f == 2'b10 && s2 == 2'b11) ||
          (f == 2'b11 && s2 == 2'b01) ||
          (f == 2'b01 && s2 == 2'b00);
    dn  = (f == 2'b10 && s2 == 2'b00) ||
          (f == 2'b11 && s2 == 2'b10) ||
          (f == 2'b01 && s2 == 2'b11) ||
          (f == 2'b00 && s2 == 2'b01);
    if (state == TRACK && s2 == f) begin
      cnt_nxt = 4'd0;
    end else if (hit) begin
      cnt_nxt = 4'd0;
      f_nxt   = s2;
      if (state == INIT) begin
        state_nxt = TRACK;
      end else begin
        unique case (1'b1)
          up: begin
            step_nxt = 1'b1;
            ud_nxt   = 1'b1;
          end
          dn: begin
            step_nxt = 1'b1;
            ud_nxt   = 1'b0;
          end
          default: err_nxt = 1'b1;
        endcase
      end
    end else begin
      cnt_nxt  = n;
      cand_nxt = s2;
    end
  end

  // State, filtered pair and registered outputs
  always_ff @(posedge C) begin
    if (CLR) begin
      state   <= INIT;
      f       <= 2'b00;
      cand    <= 2'b00;
      cnt     <= 4'd0;
      Step    <= 1'b0;
      Up_Down <= 1'b1;
      Err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      f       <= f_nxt;
      cand    <= cand_nxt;
      cnt     <= cnt_nxt;
      Step    <= step_nxt;
      Up_Down <= ud_nxt;
      Err     <= err_nxt;
    end
  end

`ifdef QDEC_ERR_CNT_EN
  logic [3:0] ecnt;

  // Saturating count of illegal jumps
  always_ff @(posedge C) begin
    if (CLR) begin
      ecnt <= 4'd0;
    end else if (err_nxt && ecnt != 4'hF) begin
      ecnt <= ecnt + 4'd1;
    end
  end

  assign Err_Cnt = ecnt;
`else
  assign Err_Cnt = 4'b0000;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: sample-history model,
// per-cycle compare, directed literal checks, random phases.
module tb_quad_step_decoder;

  localparam int FL = 4;

  logic       clk;
  logic       clr;
  logic       a;
  logic       b;
  logic       step;
  logic       up_down;
  logic       err;
  logic [3:0] err_cnt;

  int pass_cnt;
  int total_cnt;

  quad_step_decoder #(.FILT_LEN(FL)) dut (
    .C       (clk),
    .CLR     (clr),
    .A       (a),
    .B       (b),
    .Step    (step),
    .Up_Down (up_down),
    .Err     (err),
    .Err_Cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sat_err(input int k);
`ifdef QDEC_ERR_CNT_EN
    return (k > 15) ? 15 : k;
`else
    return (k > 15) ? 0 : 0;
`endif
  endfunction

  logic [1:0] ms1, ms2, mf;
  logic [1:0] hist[$];
  logic       minit, mstep, mud, merr;
  int         mcnt;
  bit         started;

  // Reference: accept a pair once the last FL s2 samples agree
  always @(posedge clk) begin
    logic [1:0] v;
    bit same;
    int d;
    if (clr) begin
      ms1 = 2'b00; ms2 = 2'b00; mf = 2'b00;
      hist.delete();
      minit = 1'b1; mstep = 1'b0; mud = 1'b1;
      merr = 1'b0; mcnt = 0;
    end else begin
      mstep = 1'b0;
      merr  = 1'b0;
      hist.push_back(ms2);
      if (hist.size() > FL) void'(hist.pop_front());
      if (hist.size() == FL) begin
        v = hist[0];
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != v) same = 1'b0;
        if (same && minit) begin
          minit = 1'b0;
          mf = v;
          hist.delete();
        end else if (same && v != mf) begin
          d = (pos(v) - pos(mf) + 4) % 4;
          if (d == 1) begin mstep = 1'b1; mud = 1'b1; end
          else if (d == 3) begin mstep = 1'b1; mud = 1'b0; end
          else begin merr = 1'b1; mcnt++; end
          mf = v;
          hist.delete();
        end
      end
      ms2 = ms1;
      ms1 = {a, b};
    end
    started = 1'b1;
  end

  // Per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (started)
      chk("cycle", int'({step, up_down, err, err_cnt}),
          int'({mstep, mud, merr, 4'(sat_err(mcnt))}));
  end

  int nup, ndn, nerr, first;

  task automatic apply(input logic [1:0] v, input int hold);
    {a, b} = v;
    nup = 0; ndn = 0; nerr = 0; first = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (step) begin
        if (up_down) nup++;
        else ndn++;
        if (first == 0) first = i;
      end
      if (err) nerr++;
    end
  endtask

  logic [1:0] useq[4];
  logic [1:0] dseq[4];
  int g, u, dd;

  initial begin
    pass_cnt = 0; total_cnt = 0; started = 1'b0;
    useq = '{2'b10, 2'b11, 2'b01, 2'b00};
    dseq = '{2'b01, 2'b11, 2'b10, 2'b00};
    clr = 1'b1; a = 1'b0; b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", int'({step, up_down, err, err_cnt}),
        int'({1'b0, 1'b1, 1'b0, 4'd0}));
    clr = 1'b0;
    apply(2'b00, 10);
    for (int i = 0; i < 4; i++) begin
      apply(useq[i], 10);
      chk($sformatf("up%0d_cnt", i), nup * 10 + ndn + nerr * 100, 10);
      chk($sformatf("up%0d_lat", i), first, FL + 2);
    end
    for (int i = 0; i < 4; i++) begin
      apply(dseq[i], 10);
      chk($sformatf("dn%0d_cnt", i), ndn * 10 + nup + nerr * 100, 10);
      chk($sformatf("dn%0d_lat", i), first, FL + 2);
    end
    apply(2'b11, 10);
    chk("err_jump", nerr * 100 + nup * 10 + ndn, 100);
    chk("err_ud", int'(up_down), 0);
    chk("err_cnt1", int'(err_cnt), sat_err(1));
    for (int i = 2; i <= 20; i++)
      apply((i % 2 == 0) ? 2'b00 : 2'b11, 8);
    chk("err_cnt20", int'(err_cnt), sat_err(20));
    apply(2'b10, 3);
    g = nup + ndn + nerr;
    apply(2'b00, 10);
    g += nup + ndn + nerr;
    chk("glitch3", g, 0);
    apply(2'b10, 4);
    u = nup; dd = ndn;
    apply(2'b00, 10);
    chk("glitch4", (u + nup) * 10 + dd + ndn, 11);
    apply(2'b10, 4);
    chk("clr_pend", nup + ndn + nerr, 0);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_out", int'({step, up_down, err, err_cnt}),
        int'({1'b0, 1'b1, 1'b0, 4'd0}));
    clr = 1'b0;
    apply(2'b10, 10);
    chk("clr_init", nup + ndn + nerr, 0);
    {a, b} = 2'b11;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    apply(2'b11, 10);
    chk("init11", nup + ndn + nerr, 0);
    apply(2'b01, 10);
    chk("init_step", nup * 10 + ndn + nerr * 100, 10);
    chk("init_ud", int'(up_down), 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
      apply(2'($urandom_range(0, 3)), $urandom_range(1, 12));
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
